nutshell_commit_tracer: RTL and testbench
=========================================

// Module: nutshell_commit_tracer
// PURPOSE
//  Parametrised successor to the single-core commit-probe wiring: captures NutShell WBU commit records
//  (pc, rf dest/wen/data, instr count) into a circular trace buffer around a programmable PC trigger.
//  Sits beside the core in coreclk domain; frozen trace drained via valid/ready port for MMIO/DMA readout.
// PARAMETERS
//  PC_W        39  width of commit PC (matches WBUpc)
//  DATA_W      64  width of rf write data / instr count
//  DEPTH_LOG2   9  log2 trace entries (DEPTH = 2**DEPTH_LOG2)
// PORTS
//  coreclk      in   1             core clock; all logic on posedge
//  corerstn     in   1             synchronous active-low reset
//  wb_valid     in   1             commit strobe (one record per high cycle)
//  wb_pc        in   PC_W          committed PC
//  wb_rf_wen    in   1             rf write enable of commit
//  wb_rf_dest   in   5             rf destination
//  wb_rf_data   in   DATA_W        rf write data
//  instr_cnt    in   DATA_W        retired-instruction counter
//  arm          in   1             pulse: clear buffer, start recording
//  trig_en      in   1             1: trigger on wb_pc==trig_pc; 0: trigger only via force_trig
//  trig_pc      in   PC_W          trigger PC
//  force_trig   in   1             pulse: immediate trigger
//  post_count   in   DEPTH_LOG2+1  commits recorded after trigger (clamped to DEPTH-1)
//  rd_valid     out  1             trace entry available
//  rd_ready     in   1             consumer accepts entry
//  rd_entry     out  ENTRY_W       {ts?, instr_cnt, rf_data, rf_wen, rf_dest, pc}
//  state        out  2             0 IDLE,1 ARMED,2 POST,3 DONE
//  wrapped      out  1             buffer overwrote oldest entry
//  level        out  DEPTH_LOG2+1  valid entries in buffer
// BEHAVIOUR
//  - Reset (corerstn=0 at posedge): state=IDLE, wr_ptr=rd_ptr=0, level=0, wrapped=0, rd_valid=0, post ctr=0.
//  - IDLE: wb_valid ignored. arm -> ARMED (ptrs/level/wrapped cleared same edge).
//  - ARMED: each wb_valid writes entry at wr_ptr, wr_ptr+=1 mod DEPTH; level saturates at DEPTH;
//    write when level==DEPTH advances rd_ptr (drop oldest), sets wrapped (sticky until arm/reset).
//  - Trigger = force_trig | (trig_en & wb_valid & wb_pc==trig_pc), evaluated only in ARMED.
//    Triggering commit is recorded and not counted; post ctr loaded with min(post_count,DEPTH-1).
//    post ctr==0 at trigger -> DONE next edge; else -> POST.
//  - POST: each wb_valid recorded, post ctr-=1; reaching 0 -> DONE. Further triggers ignored.
//  - DONE: writes inhibited. Oldest entry (rd_ptr) presented; rd_valid rises 1 cycle after entering DONE
//    (registered RAM read). Handshake rd_valid&rd_ready pops: rd_ptr+=1, level-=1, next entry
//    valid following cycle (1 bubble per pop allowed; back-to-back not required). level==0 -> rd_valid=0, IDLE.
//  - rd_entry is don't-care when rd_valid=0; must be stable while rd_valid&!rd_ready.
//  - arm in any state restarts (ARMED, buffer cleared) and wins over trigger/pop in the same cycle.
//  - force_trig outside ARMED ignored; arm during POST/DONE discards trace.
//  - wb_valid=1 same cycle as arm: commit NOT recorded (recording begins next cycle).
//  - Storage single-port-inferable: one write or one read per cycle (DONE reads only, never writes).
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined: 32-bit free-running cycle counter (reset 0, wraps) sampled per record
//    and prepended as rd_entry MSBs; ENTRY_W = 32+DATA_W*2+1+5+PC_W.
//  Undefined: no counter; ENTRY_W = DATA_W*2+1+5+PC_W.
// TESTING
//  1) arm, 10 commits pc=0x80000000+4i, no trigger -> state=ARMED, level=10, wrapped=0.
//  2) DEPTH=8 bench: arm, 20 commits, force_trig with post_count=0 -> DONE; drain 8 entries, pcs of
//     commits 12..19 in order, wrapped=1, then IDLE, rd_valid=0.
//  3) trig_en=1, trig_pc=0x80000040, post_count=3, commits pc step 4 from 0x80000000 -> last entry
//     pc=0x8000004C, level=20 (DEPTH>=20), state DONE.
//  4) post_count=DEPTH+5 -> clamped; trace holds exactly DEPTH entries ending DEPTH-1 after trigger.
//  5) drain with rd_ready random 30% -> entries in order, none dropped/duplicated, entry stable while stalled.
//  6) corerstn low mid-POST for 1 cycle -> state=IDLE, level=0, wrapped=0; with TRACE_TIMESTAMP_EN,
//     2 commits 5 cycles apart after arm -> ts delta == 5.

Source files
------------

// File: rtl/nutshell_commit_tracer.sv
// Circular commit-trace buffer for the NutShell WBU: records commits around a PC trigger, then drains
// the frozen trace over a valid/ready port. Optional build macro: TRACE_TIMESTAMP_EN (32-bit cycle stamp).
module nutshell_commit_tracer #(
    parameter int PC_W       = 39,
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 9,
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W      = 32,
`else
    localparam int TS_W      = 0,
`endif
    localparam int ENTRY_W   = TS_W + DATA_W*2 + 1 + 5 + PC_W
) (
    input  logic                  coreclk,
    input  logic                  corerstn,
    input  logic                  wb_valid,
    input  logic [PC_W-1:0]       wb_pc,
    input  logic                  wb_rf_wen,
    input  logic [4:0]            wb_rf_dest,
    input  logic [DATA_W-1:0]     wb_rf_data,
    input  logic [DATA_W-1:0]     instr_cnt,
    input  logic                  arm,
    input  logic                  trig_en,
    input  logic [PC_W-1:0]       trig_pc,
    input  logic                  force_trig,
    input  logic [DEPTH_LOG2:0]   post_count,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ENTRY_W-1:0]    rd_entry,
    output logic [1:0]            state,
    output logic                  wrapped,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   POST_MAX = (DEPTH_LOG2+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                  state_r;
    state_e                  next_state_s;
    logic [DEPTH_LOG2-1:0]   wr_ptr_r;
    logic [DEPTH_LOG2-1:0]   rd_ptr_r;
    logic [DEPTH_LOG2:0]     level_r;
    logic                    wrapped_r;
    logic                    rd_valid_r;
    logic [DEPTH_LOG2-1:0]   post_ctr_r;
    logic [ENTRY_W-1:0]      rd_entry_r;
    logic [ENTRY_W-1:0]      mem_r [DEPTH];

    logic                    trig_s;
    logic                    wr_en_s;
    logic                    rd_en_s;
    logic                    pop_s;
    logic [DEPTH_LOG2-1:0]   post_load_s;
    logic [ENTRY_W-1:0]      entry_s;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]             ts_r;

    // Free-running cycle stamp shared by all records
    always_ff @(posedge coreclk) begin
        if (!corerstn) begin
            ts_r <= 32'd0;
        end else begin
            ts_r <= ts_r + 32'd1;
        end
    end

    assign entry_s = {ts_r, instr_cnt, wb_rf_data, wb_rf_wen, wb_rf_dest, wb_pc};
`else
    assign entry_s = {instr_cnt, wb_rf_data, wb_rf_wen, wb_rf_dest, wb_pc};
`endif

    // Trigger-window FSM: next state plus the write/read/pop strobes; arm overrides everything
    always_comb begin
        next_state_s = state_r;
        trig_s       = 1'b0;
        wr_en_s      = 1'b0;
        rd_en_s      = 1'b0;
        pop_s        = 1'b0;
        post_load_s  = (post_count >= POST_MAX) ? POST_MAX[DEPTH_LOG2-1:0]
                                                : post_count[DEPTH_LOG2-1:0];
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    next_state_s = ST_ARMED;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (arm) begin
                    next_state_s = ST_ARMED;
                end else begin
                    wr_en_s = wb_valid;
                    trig_s  = force_trig | (trig_en & wb_valid & (wb_pc == trig_pc));
                    if (trig_s) begin
                        next_state_s = (post_load_s == '0) ? ST_DONE : ST_POST;
                    end else begin
                        next_state_s = ST_ARMED;
                    end
                end
            end
            ST_POST: begin
                if (arm) begin
                    next_state_s = ST_ARMED;
                end else begin
                    wr_en_s = wb_valid;
                    if (wb_valid && (post_ctr_r == PTR_ONE)) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_POST;
                    end
                end
            end
            ST_DONE: begin
                if (arm) begin
                    next_state_s = ST_ARMED;
                end else if (level_r == '0) begin
                    next_state_s = ST_IDLE;
                end else if (rd_valid_r && rd_ready) begin
                    pop_s = 1'b1;
                    if (level_r == LVL_ONE) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    // Refill the output register one cycle after each pop
                    rd_en_s = ~rd_valid_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Pointers, fill level, wrap flag, post-trigger counter and output-valid flag
    always_ff @(posedge coreclk) begin
        if (!corerstn) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            wrapped_r  <= 1'b0;
            rd_valid_r <= 1'b0;
            post_ctr_r <= '0;
        end else begin
            state_r <= next_state_s;
            if (arm) begin
                wr_ptr_r   <= '0;
                rd_ptr_r   <= '0;
                level_r    <= '0;
                wrapped_r  <= 1'b0;
                rd_valid_r <= 1'b0;
                post_ctr_r <= '0;
            end else begin
                if (wr_en_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                    if (level_r == LVL_FULL) begin
                        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
                        wrapped_r <= 1'b1;
                    end else begin
                        level_r <= level_r + LVL_ONE;
                    end
                end
                if (trig_s) begin
                    post_ctr_r <= post_load_s;
                end else if ((state_r == ST_POST) && wb_valid) begin
                    post_ctr_r <= post_ctr_r - PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                    level_r    <= level_r - LVL_ONE;
                    rd_valid_r <= 1'b0;
                end else if (rd_en_s) begin
                    rd_valid_r <= 1'b1;
                end
            end
        end
    end

    // Single-port trace storage: recording states write, DONE reads into the output register
    always_ff @(posedge coreclk) begin
        if (corerstn && wr_en_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end else if (corerstn && rd_en_s) begin
            rd_entry_r <= mem_r[rd_ptr_r];
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_entry = rd_entry_r;
    assign state    = state_r;
    assign wrapped  = wrapped_r;
    assign level    = level_r;

endmodule

// File: tb/tb_nutshell_commit_tracer.sv
// Self-checking bench for nutshell_commit_tracer (DEPTH=8): directed scenarios plus randomized
// windows, checked against a queue-based trace model.
module tb_nutshell_commit_tracer;

    localparam int PC_W   = 39;
    localparam int DATA_W = 64;
    localparam int DL2    = 3;
    localparam int DEPTH  = 2 ** DL2;
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W = 32;
`else
    localparam int TS_W = 0;
`endif
    localparam int BODY_W  = DATA_W*2 + 1 + 5 + PC_W;
    localparam int ENTRY_W = TS_W + BODY_W;
    localparam int M_IDLE = 0, M_ARMED = 1, M_POST = 2, M_DONE = 3;

    logic                coreclk = 1'b0;
    logic                corerstn;
    logic                wb_valid;
    logic [PC_W-1:0]     wb_pc;
    logic                wb_rf_wen;
    logic [4:0]          wb_rf_dest;
    logic [DATA_W-1:0]   wb_rf_data;
    logic [DATA_W-1:0]   instr_cnt;
    logic                arm;
    logic                trig_en;
    logic [PC_W-1:0]     trig_pc;
    logic                force_trig;
    logic [DL2:0]        post_count;
    logic                rd_valid;
    logic                rd_ready;
    logic [ENTRY_W-1:0]  rd_entry;
    logic [1:0]          state;
    logic                wrapped;
    logic [DL2:0]        level;

    nutshell_commit_tracer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH_LOG2(DL2)) dut (
        .coreclk(coreclk), .corerstn(corerstn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_rf_wen(wb_rf_wen), .wb_rf_dest(wb_rf_dest), .wb_rf_data(wb_rf_data),
        .instr_cnt(instr_cnt), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .force_trig(force_trig), .post_count(post_count), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_entry(rd_entry), .state(state), .wrapped(wrapped),
        .level(level)
    );

    always #5 coreclk = ~coreclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the trace is a queue of records, oldest first
    int                 m_state;
    logic [BODY_W-1:0]  m_q[$];
    logic               m_wrapped;
    int                 m_post;
    logic [ENTRY_W-1:0] popped[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge coreclk);
        #1;
    endtask

    task automatic record();
        m_q.push_back({instr_cnt, wb_rf_data, wb_rf_wen, wb_rf_dest, wb_pc});
        if (m_q.size() > DEPTH) begin
            void'(m_q.pop_front());
            m_wrapped = 1'b1;
        end
    endtask

    task automatic model_edge();
        if (!corerstn || arm) begin
            m_state   = corerstn ? M_ARMED : M_IDLE;
            m_q.delete();
            m_wrapped = 1'b0;
        end else if (m_state == M_ARMED) begin
            if (wb_valid) record();
            if (force_trig || (trig_en && wb_valid && wb_pc == trig_pc)) begin
                m_post  = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
                m_state = (m_post == 0) ? M_DONE : M_POST;
            end
        end else if (m_state == M_POST && wb_valid) begin
            record();
            m_post--;
            if (m_post == 0) m_state = M_DONE;
        end
    endtask

    task automatic tick();
        model_edge();
        cyc();
        arm        = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic commit(input logic [PC_W-1:0] pc);
        wb_valid   = 1'b1;
        wb_pc      = pc;
        wb_rf_wen  = 1'($urandom);
        wb_rf_dest = 5'($urandom);
        wb_rf_data = {$urandom, $urandom};
        instr_cnt  = {$urandom, $urandom};
        tick();
        wb_valid   = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_state"}, 256'(state), 256'(m_state));
        chk({tag, "_level"}, 256'(level), 256'(m_q.size()));
        chk({tag, "_wrapped"}, 256'(wrapped), 256'(m_wrapped));
    endtask

    task automatic drain(input int ready_pct);
        int budget = 2000;
        logic [ENTRY_W-1:0] held = '0;
        bit stalled = 1'b0;
        popped.delete();
        while (m_q.size() > 0 && budget > 0) begin
            budget--;
            chk("drain_level", 256'(level), 256'(m_q.size()));
            if (rd_valid) begin
                chk("drain_entry", 256'(rd_entry[BODY_W-1:0]), 256'(m_q[0]));
                if (stalled) chk("drain_stable", 256'(rd_entry), 256'(held));
                rd_ready = ($urandom_range(99) < ready_pct);
                if (rd_ready) begin
                    popped.push_back(rd_entry);
                    void'(m_q.pop_front());
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = rd_entry;
                end
            end else begin
                rd_ready = 1'b0;
            end
            cyc();
        end
        rd_ready = 1'b0;
        if (budget == 0) chk("drain_timeout", 256'(1), 256'(0));
        m_state = M_IDLE;
        chk("drain_end_state", 256'(state), 256'(M_IDLE));
        chk("drain_end_valid", 256'(rd_valid), 256'(0));
        chk("drain_end_level", 256'(level), 256'(0));
    endtask

    initial begin
        logic [PC_W-1:0] base;
        int n_pre;
        int i;
        corerstn = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_rf_wen = 1'b0; wb_rf_dest = '0;
        wb_rf_data = '0; instr_cnt = '0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
        force_trig = 1'b0; post_count = '0; rd_ready = 1'b0;
        m_state = M_IDLE; m_wrapped = 1'b0; m_post = 0;
        tick();
        tick();
        corerstn = 1'b1;
        check_status("reset");
        chk("reset_rd_valid", 256'(rd_valid), 256'(0));

        // Scenario 1: arm with a simultaneous commit (dropped), then 10 commits
        arm = 1'b1; wb_valid = 1'b1; wb_pc = 39'h7ffff0000;
        tick();
        wb_valid = 1'b0;
        for (int k = 0; k < 10; k++) commit(39'(64'h80000000 + 4*k));
        check_status("s1");

        // Scenario 2: wrap, force trigger with zero post count, drain in order
        for (int k = 10; k < 20; k++) commit(39'(64'h80000000 + 4*k));
        check_status("s2_wrap");
        post_count = '0; force_trig = 1'b1;
        tick();
        check_status("s2_done");
        chk("s2_valid_lag", 256'(rd_valid), 256'(0));
        cyc();
        chk("s2_valid_rise", 256'(rd_valid), 256'(1));
        drain(100);
        chk("s2_first_pc", 256'(popped[0][PC_W-1:0]), 256'(39'h80000030));
        chk("s2_wrapped_kept", 256'(wrapped), 256'(1));
        force_trig = 1'b1;
        tick();
        chk("s2_idle_force_ignored", 256'(state), 256'(M_IDLE));

        // Scenario 3: PC trigger with post_count=3
        arm = 1'b1; trig_en = 1'b1; trig_pc = 39'h80000040; post_count = 4'd3;
        tick();
        i = 0;
        while (m_state != M_DONE && i < 100) begin
            commit(39'(64'h80000000 + 4*i));
            i++;
        end
        commit(39'h80000040);
        commit(39'h80000100);
        check_status("s3");
        drain(100);
        chk("s3_last_pc", 256'(popped[popped.size()-1][PC_W-1:0]), 256'(39'h8000004C));

        // Scenario 4/5: clamped post count, random-ready drain
        arm = 1'b1; trig_pc = 39'h80000010; post_count = 4'(DEPTH + 5);
        tick();
        for (int k = 0; k < 30; k++) commit(39'(64'h80000000 + 4*k));
        check_status("s4");
        drain(30);
        chk("s4_count", 256'(popped.size()), 256'(DEPTH));
        chk("s4_first_pc", 256'(popped[0][PC_W-1:0]), 256'(39'h80000010));

        // Scenario 6: reset mid-POST
        arm = 1'b1; trig_pc = 39'h80000024; post_count = 4'd5;
        tick();
        for (int k = 0; k < 11; k++) commit(39'(64'h80000000 + 4*k));
        check_status("s6_post");
        corerstn = 1'b0;
        tick();
        corerstn = 1'b1;
        check_status("s6_reset");

        // Two commits five cycles apart
        arm = 1'b1; trig_en = 1'b0;
        tick();
        commit(39'h80001000);
        for (int k = 0; k < 4; k++) tick();
        commit(39'h80001004);
        post_count = '0; force_trig = 1'b1;
        tick();
        check_status("s6_done");
        drain(60);
`ifdef TRACE_TIMESTAMP_EN
        chk("s6_ts_delta", 256'(popped[1][ENTRY_W-1 -: 32] - popped[0][ENTRY_W-1 -: 32]),
            256'(32'd5));
`endif

        // Randomized trigger windows with random gaps and post counts
        for (int r = 0; r < 6; r++) begin
            base       = PC_W'($urandom) & ~39'h3;
            n_pre      = $urandom_range(15, 1);
            trig_en    = 1'($urandom);
            trig_pc    = base + PC_W'(4 * n_pre);
            post_count = 4'($urandom_range(DEPTH + 3, 0));
            arm = 1'b1;
            tick();
            i = 0;
            while (m_state != M_DONE && i < 100) begin
                if (i == n_pre && !trig_en) force_trig = 1'b1;
                commit(base + PC_W'(4 * i));
                for (int g = $urandom_range(2, 0); g > 0; g--) tick();
                i++;
            end
            if (i >= 100) chk("rand_no_done", 256'(1), 256'(0));
            check_status("rand");
            drain($urandom_range(80, 20));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
